// File: rtl/ewrapper_link_rx_arbiter_if.sv
// Link-receiver to emesh bundle: write/read channel inputs,
// per-channel waits, merged output slot and error flag.
interface ewrapper_link_rx_arbiter_if;
  logic         wr_access;
  logic [102:0] wr_tran;
  logic         rd_access;
  logic [102:0] rd_tran;
  logic         wr_wait;
  logic         rd_wait;
  logic         emesh_wr_wait_outb;
  logic         emesh_rd_wait_outb;
  logic         emesh_access_inb;
  logic [102:0] emesh_tran_inb;
  logic         emesh_grant_rd;
  logic         overflow_err;

  modport slave (
    input  wr_access, wr_tran,
    input  rd_access, rd_tran,
    input  emesh_wr_wait_outb,
    input  emesh_rd_wait_outb,
    output wr_wait, rd_wait,
    output emesh_access_inb,
    output emesh_tran_inb,
    output emesh_grant_rd,
    output overflow_err
  );

  modport master (
    output wr_access, wr_tran,
    output rd_access, rd_tran,
    output emesh_wr_wait_outb,
    output emesh_rd_wait_outb,
    input  wr_wait, rd_wait,
    input  emesh_access_inb,
    input  emesh_tran_inb,
    input  emesh_grant_rd,
    input  overflow_err
  );
endinterface

// File: rtl/ewrapper_link_rx_arbiter.sv
// Merges link-rx write and read streams into one emesh port:
// 2-deep FIFO per channel, write priority, read starvation guard.
module ewrapper_link_rx_arbiter #(
  parameter int unsigned RD_STARVE_MAX = 8
) (
  input logic                      rxi_lclk,
  input logic                      reset,
  ewrapper_link_rx_arbiter_if.slave lnk
);

  localparam logic [3:0] STV_MAX = 4'(RD_STARVE_MAX);

  typedef enum logic {S_EMPTY, S_VALID} slot_e;

  slot_e        state_q, state_d;
  logic [1:0]   wocc_q, wocc_d;
  logic [1:0]   rocc_q, rocc_d;
  logic [102:0] wf_q [2];
  logic [102:0] wf_d [2];
  logic [102:0] rf_q [2];
  logic [102:0] rf_d [2];
  logic [102:0] tran_q, tran_d;
  logic         grd_q, grd_d;
  logic [3:0]   stv_q, stv_d;
  logic         err_q, err_d;

  logic wwait, rwait;
  logic wpush, rpush;
  logic welig, relig;
  logic blk, load;
  logic gw, gr;
  logic widx, ridx;

  assign wwait = (wocc_q == 2'd2);
  assign rwait = (rocc_q == 2'd2);

  always_comb begin
    wpush = lnk.wr_access & ~wwait;
    rpush = lnk.rd_access & ~rwait;
    welig = (wocc_q != 2'd0) & ~lnk.emesh_wr_wait_outb;
    relig = (rocc_q != 2'd0) & ~lnk.emesh_rd_wait_outb
          & ~lnk.emesh_wr_wait_outb;
    blk   = grd_q ? (lnk.emesh_wr_wait_outb | lnk.emesh_rd_wait_outb)
                  : lnk.emesh_wr_wait_outb;
    load  = (state_q == S_EMPTY) | ~blk;
    gw    = 1'b0;
    gr    = 1'b0;
    if (load) begin
      if ((stv_q == STV_MAX) && relig) gr = 1'b1;
      else if (welig)                  gw = 1'b1;
      else if (relig)                  gr = 1'b1;
    end
  end

  // FIFO head stays in slot 0; a push lands behind whatever survives the pop
  always_comb begin
    wf_d   = wf_q;
    rf_d   = rf_q;
    widx   = wocc_q[1] | (wocc_q[0] & ~gw);
    ridx   = rocc_q[1] | (rocc_q[0] & ~gr);
    if (gw)    wf_d[0]    = wf_q[1];
    if (wpush) wf_d[widx] = lnk.wr_tran;
    if (gr)    rf_d[0]    = rf_q[1];
    if (rpush) rf_d[ridx] = lnk.rd_tran;
    wocc_d = wocc_q + {1'b0, wpush} - {1'b0, gw};
    rocc_d = rocc_q + {1'b0, rpush} - {1'b0, gr};
  end

  always_comb begin
    state_d = state_q;
    tran_d  = tran_q;
    grd_d   = grd_q;
    if (load) begin
      state_d = (gw | gr) ? S_VALID : S_EMPTY;
      if (gw | gr) begin
        tran_d = gr ? rf_q[0] : wf_q[0];
        grd_d  = gr;
      end
    end
  end

  always_comb begin
    stv_d = stv_q;
    if (rocc_q == 2'd0)                stv_d = 4'd0;
    else if (gr)                       stv_d = 4'd0;
    else if (gw && (stv_q != STV_MAX)) stv_d = stv_q + 4'd1;
    err_d = err_q
          | (lnk.wr_access & wwait)
          | (lnk.rd_access & rwait);
  end

  always_ff @(posedge rxi_lclk) begin
    if (reset) begin
      state_q <= S_EMPTY;
      wocc_q  <= 2'd0;
      rocc_q  <= 2'd0;
      wf_q[0] <= '0;
      wf_q[1] <= '0;
      rf_q[0] <= '0;
      rf_q[1] <= '0;
      tran_q  <= '0;
      grd_q   <= 1'b0;
      stv_q   <= 4'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wocc_q  <= wocc_d;
      rocc_q  <= rocc_d;
      wf_q    <= wf_d;
      rf_q    <= rf_d;
      tran_q  <= tran_d;
      grd_q   <= grd_d;
      stv_q   <= stv_d;
      err_q   <= err_d;
    end
  end

  assign lnk.wr_wait          = wwait;
  assign lnk.rd_wait          = rwait;
  assign lnk.emesh_access_inb = (state_q == S_VALID);
  assign lnk.emesh_tran_inb   = tran_q;
  assign lnk.emesh_grant_rd   = grd_q;
  assign lnk.overflow_err     = err_q;

endmodule

// File: tb/tb_ewrapper_link_rx_arbiter.sv
// Scoreboard bench for ewrapper_link_rx_arbiter: directed phases
// queue expected outputs, a negedge monitor pops and compares.
module tb_ewrapper_link_rx_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ewrapper_link_rx_arbiter_if bus ();

  ewrapper_link_rx_arbiter #(.RD_STARVE_MAX(8)) dut (
    .rxi_lclk (clk),
    .reset    (rst),
    .lnk      (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [103:0] exq [$];
  logic [103:0] ex;
  logic         pv;
  logic [102:0] ptran;
  logic         pgrd;
  logic         mblk;

  function automatic logic [102:0] mk(input logic w, input int id);
    logic [31:0] d;
    d = 32'(id);
    return {w, 2'b10, 4'h3, 32'h8000_0000 | d, 32'h0000_a000 | d, d};
  endfunction

  task automatic chk(input string nm, input logic [102:0] act,
                     input logic [102:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic exp_out(input logic rd, input logic [102:0] t);
    exq.push_back({rd, t});
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input logic [102:0] t);
    int n;
    n = 0;
    while (bus.wr_wait && n < 20) begin
      bus.wr_access = 1'b0;
      step;
      n++;
    end
    if (bus.wr_wait) begin
      total++;
      bad++;
      $display("FAIL push_wr_timeout actual=%b required=0", bus.wr_wait);
    end
    bus.wr_access = 1'b1;
    bus.wr_tran   = t;
    step;
    bus.wr_access = 1'b0;
  endtask

  task automatic drain(input string nm);
    int n;
    n = 0;
    while (exq.size() != 0 && n < 60) begin
      step;
      n++;
    end
    step;
    total++;
    if (exq.size() != 0) begin
      bad++;
      $display("FAIL %s actual=%0d_left required=0_left", nm, exq.size());
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
    end else begin
      if (pv && bus.emesh_access_inb) begin
        chk("hold_tran", bus.emesh_tran_inb, ptran);
        chk("hold_grant", 103'(bus.emesh_grant_rd), 103'(pgrd));
      end
      if (bus.emesh_access_inb) begin
        mblk = bus.emesh_grant_rd
             ? (bus.emesh_wr_wait_outb | bus.emesh_rd_wait_outb)
             : bus.emesh_wr_wait_outb;
        if (!mblk) begin
          if (exq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_out actual=%h required=none",
                     bus.emesh_tran_inb);
          end else begin
            ex = exq.pop_front();
            chk("out_tran", bus.emesh_tran_inb, ex[102:0]);
            chk("out_grant_rd", 103'(bus.emesh_grant_rd), 103'(ex[103]));
          end
        end
        pv    = mblk;
        ptran = bus.emesh_tran_inb;
        pgrd  = bus.emesh_grant_rd;
      end else begin
        pv = 1'b0;
      end
    end
  end

  initial begin
    rst                    = 1'b1;
    bus.wr_access          = 1'b1;
    bus.wr_tran            = mk(1'b1, 999);
    bus.rd_access          = 1'b0;
    bus.rd_tran            = '0;
    bus.emesh_wr_wait_outb = 1'b0;
    bus.emesh_rd_wait_outb = 1'b0;

    // reset with write access asserted
    repeat (3) step;
    chk("rst_access", 103'(bus.emesh_access_inb), 103'(0));
    chk("rst_tran", bus.emesh_tran_inb, 103'(0));
    chk("rst_grant_rd", 103'(bus.emesh_grant_rd), 103'(0));
    chk("rst_wr_wait", 103'(bus.wr_wait), 103'(0));
    chk("rst_rd_wait", 103'(bus.rd_wait), 103'(0));
    chk("rst_overflow", 103'(bus.overflow_err), 103'(0));
    bus.wr_access = 1'b0;
    rst = 1'b0;

    // write streaming, 0..9
    for (int i = 0; i < 10; i++) exp_out(1'b0, mk(1'b1, i));
    for (int i = 0; i < 10; i++) begin
      bus.wr_access = 1'b1;
      bus.wr_tran   = mk(1'b1, i);
      step;
      chk("stream_wr_wait", 103'(bus.wr_wait), 103'(0));
      if (i == 0)
        chk("lat_not_yet", 103'(bus.emesh_access_inb), 103'(0));
      if (i == 1) begin
        chk("lat_first_valid", 103'(bus.emesh_access_inb), 103'(1));
        chk("lat_first_tran", bus.emesh_tran_inb, mk(1'b1, 0));
      end
    end
    bus.wr_access = 1'b0;
    step;
    chk("stream_last", bus.emesh_tran_inb, mk(1'b1, 9));
    drain("drain_stream");

    // starvation: read waits for exactly 8 write grants
    for (int i = 0; i < 8; i++) exp_out(1'b0, mk(1'b1, 100 + i));
    exp_out(1'b1, mk(1'b0, 150));
    for (int i = 8; i < 12; i++) exp_out(1'b0, mk(1'b1, 100 + i));
    bus.rd_access = 1'b1;
    bus.rd_tran   = mk(1'b0, 150);
    push_wr(mk(1'b1, 100));
    bus.rd_access = 1'b0;
    for (int i = 1; i < 12; i++) push_wr(mk(1'b1, 100 + i));
    drain("drain_starve");

    // write-side backpressure holds slot and fills both FIFOs
    exp_out(1'b0, mk(1'b1, 200));
    exp_out(1'b0, mk(1'b1, 201));
    exp_out(1'b0, mk(1'b1, 202));
    exp_out(1'b1, mk(1'b0, 200));
    exp_out(1'b1, mk(1'b0, 201));
    bus.wr_access = 1'b1;
    bus.wr_tran   = mk(1'b1, 200);
    bus.rd_access = 1'b1;
    bus.rd_tran   = mk(1'b0, 200);
    step;
    bus.wr_tran   = mk(1'b1, 201);
    bus.rd_access = 1'b0;
    step;
    bus.emesh_wr_wait_outb = 1'b1;
    bus.wr_tran   = mk(1'b1, 202);
    bus.rd_access = 1'b1;
    bus.rd_tran   = mk(1'b0, 201);
    step;
    bus.wr_access = 1'b0;
    bus.rd_access = 1'b0;
    chk("bp_wr_wait_hi", 103'(bus.wr_wait), 103'(1));
    chk("bp_rd_wait_hi", 103'(bus.rd_wait), 103'(1));
    chk("bp_held_valid", 103'(bus.emesh_access_inb), 103'(1));
    chk("bp_held_tran", bus.emesh_tran_inb, mk(1'b1, 200));
    repeat (5) step;
    chk("bp_still_held", bus.emesh_tran_inb, mk(1'b1, 200));
    bus.emesh_wr_wait_outb = 1'b0;
    step;
    chk("bp_wr_wait_drop", 103'(bus.wr_wait), 103'(0));
    chk("bp_rd_wait_keep", 103'(bus.rd_wait), 103'(1));
    step;
    chk("bp_rd_wait_keep2", 103'(bus.rd_wait), 103'(1));
    step;
    chk("bp_rd_wait_drop", 103'(bus.rd_wait), 103'(0));
    drain("drain_bp");

    // read-only backpressure: writes flow, read held
    for (int i = 0; i < 4; i++) exp_out(1'b0, mk(1'b1, 300 + i));
    exp_out(1'b1, mk(1'b0, 300));
    bus.emesh_rd_wait_outb = 1'b1;
    bus.rd_access = 1'b1;
    bus.rd_tran   = mk(1'b0, 300);
    push_wr(mk(1'b1, 300));
    bus.rd_access = 1'b0;
    for (int i = 1; i < 4; i++) push_wr(mk(1'b1, 300 + i));
    step;
    step;
    chk("rdbp_read_held", 103'(bus.emesh_access_inb), 103'(0));
    bus.emesh_rd_wait_outb = 1'b0;
    drain("drain_rdbp");

    // overflow: access into a full write FIFO is dropped
    exp_out(1'b0, mk(1'b1, 400));
    exp_out(1'b0, mk(1'b1, 401));
    bus.emesh_wr_wait_outb = 1'b1;
    bus.wr_access = 1'b1;
    bus.wr_tran   = mk(1'b1, 400);
    step;
    bus.wr_tran   = mk(1'b1, 401);
    step;
    chk("ovf_full", 103'(bus.wr_wait), 103'(1));
    chk("ovf_not_yet", 103'(bus.overflow_err), 103'(0));
    bus.wr_tran   = mk(1'b1, 499);
    step;
    bus.wr_access = 1'b0;
    chk("ovf_set", 103'(bus.overflow_err), 103'(1));
    chk("ovf_still_full", 103'(bus.wr_wait), 103'(1));
    bus.emesh_wr_wait_outb = 1'b0;
    drain("drain_ovf");
    chk("ovf_sticky", 103'(bus.overflow_err), 103'(1));

    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("ovf_cleared", 103'(bus.overflow_err), 103'(0));
    chk("final_access", 103'(bus.emesh_access_inb), 103'(0));
    chk("final_tran", bus.emesh_tran_inb, 103'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ewrapper_link_rx_arbiter.md
Name: ewrapper_link_rx_arbiter

Overview:
- Registered arbiter that merges the write-channel and read-channel transaction streams of the link receiver into the single inbound emesh port.
- Buffers each channel in a 2-entry FIFO and returns a per-channel wait to its receiver.
- Writes have priority, with a starvation counter that forces a read grant after a bounded run of writes.
- Holds the output transaction stable under downstream wait.

Parameters:
- RD_STARVE_MAX, 8: consecutive write grants allowed while a read is pending before a read grant is forced. Legal range 1..15; counter is 4 bits.

Ports:
- rxi_lclk  in  1  clock; all logic in this single domain
- reset  in  1  synchronous, active-high
- wr_access  in  1  write-channel transaction valid
- wr_tran  in  103  write-channel packed transaction
- rd_access  in  1  read-channel transaction valid
- rd_tran  in  103  read-channel packed transaction
- wr_wait  out  1  write-channel FIFO full
- rd_wait  out  1  read-channel FIFO full
- emesh_wr_wait_outb  in  1  downstream write wait
- emesh_rd_wait_outb  in  1  downstream read wait
- emesh_access_inb  out  1  output transaction valid
- emesh_tran_inb  out  103  output packed transaction
- emesh_grant_rd  out  1  1 = current output came from the read channel
- overflow_err  out  1  sticky protocol-violation flag

Packed layout, all 103-bit buses:
- [102] write
- [101:100] datamode
- [99:96] ctrlmode
- [95:64] dstaddr
- [63:32] srcaddr
- [31:0] data

Behaviour:
- Reset (synchronous) clears all state, so reset mid-operation drops buffered and held transactions. Reset values:
  - FIFO occupancies 0
  - wr_wait = rd_wait = 0
  - emesh_access_inb = 0, emesh_tran_inb = 0, emesh_grant_rd = 0
  - starvation counter 0
  - overflow_err = 0
- FIFOs, one per channel, depth 2, occupancy 0..2:
  - wait output = (occupancy == 2), driven directly from registers.
  - Push when access=1 and wait=0.
  - Access while wait=1 is dropped and sets overflow_err until reset.
  - Push and pop in the same cycle are allowed: occupancy unchanged, ordering preserved.
  - Entries are popped in arrival order.
- Output slot has two states, EMPTY and VALID.
  - emesh_access_inb = 1 in VALID.
  - The blocking wait is emesh_wr_wait_outb for a write-channel grant, and emesh_wr_wait_outb | emesh_rd_wait_outb for a read-channel grant.
  - A VALID slot is consumed in a cycle when its blocking wait = 0.
  - While blocked, emesh_tran_inb and emesh_grant_rd hold stable.
  - The slot loads when EMPTY or consumed this cycle: VALID if a grant is made, else EMPTY.
- Eligibility:
  - wr_elig = wr_occ > 0 & ~emesh_wr_wait_outb
  - rd_elig = rd_occ > 0 & ~emesh_rd_wait_outb & ~emesh_wr_wait_outb
- Grant priority, evaluated only at slot load; the granted FIFO head is popped on the same edge:
  - If starve_cnt == RD_STARVE_MAX and rd_elig: grant read.
  - Else if wr_elig: grant write.
  - Else if rd_elig: grant read.
- Starvation counter, on each grant:
  - Increments on a write grant while rd_occ > 0; saturates at RD_STARVE_MAX.
  - Clears on a read grant, or on any cycle with rd_occ == 0.
- Latency and throughput:
  - A transaction pushed at edge N is earliest visible on the output in cycle N+2.
  - Sustained throughput is 1 transaction/cycle with no downstream wait.
- Simultaneous events:
  - Both FIFOs pushing while the slot is consumed is legal.
  - Downstream wait rising on the same cycle as a load prevents the grant: eligibility is sampled that cycle.

Test Plan:
- Reset/idle: hold reset 3 cycles with wr_access=1 -> all outputs 0, occupancies 0. Release -> first write visible 2 cycles after the first post-reset push.
- Write streaming: 10 back-to-back writes, data 0..9, no waits -> outputs 0..9 in order on consecutive cycles, wr_wait never high, emesh_grant_rd=0.
- Starvation, RD_STARVE_MAX=8: continuous writes plus one read pushed at cycle 0 -> exactly 8 write grants, then the read with emesh_grant_rd=1, then writes resume; counter back to 0.
- Write backpressure: emesh_wr_wait_outb=1 for 6 cycles with writes and reads pending:
  - The held output stays stable; no grants.
  - wr_wait and rd_wait go high once both FIFOs hold 2 entries.
  - On release: wr_wait and rd_wait drop in turn, no loss, order preserved.
- Read-only backpressure: emesh_rd_wait_outb=1 with reads and writes pending -> writes flow every cycle, reads are held. Release -> reads are granted when no write is eligible, or via the starvation rule.
- Overflow: drive wr_access with wr_wait=1 -> transaction dropped, overflow_err=1 and sticky until reset; FIFO contents unaffected.
